// File: rtl/xswitch_param.sv
`timescale 1ns/1ps
// xswitch_param: address-routed NPORTS x NPORTS crossbar, round-robin arbiter and show-ahead FIFO per output.
// data_rcv is combinational in the accept cycle; a losing or blocked (full FIFO) input sees data_rcv=0 and holds.
module xswitch_param #(
  parameter int NPORTS = 8,
  parameter int DW     = 8,
  parameter int AW     = 8,
  parameter int DEPTH  = 8,
  parameter int AE_LVL = 2,
  parameter int AF_LVL = DEPTH - 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NPORTS*AW-1:0] addr_in,
  input  logic [NPORTS*DW-1:0] data_in,
  input  logic [NPORTS-1:0]    wr_en,
  output logic [NPORTS-1:0]    data_rcv,
  output logic [NPORTS*AW-1:0] addr_out,
  output logic [NPORTS*DW-1:0] data_out,
  output logic [NPORTS-1:0]    data_rdy,
  input  logic [NPORTS-1:0]    rd_en,
  input  logic                 port_en,
  input  logic                 port_wr,
  input  logic [NPORTS-1:0]    port_sel,
  input  logic [AW-1:0]        port_addr,
  output logic [NPORTS-1:0]    fifo_empty,
  output logic [NPORTS-1:0]    fifo_full,
  output logic [NPORTS-1:0]    fifo_ae,
  output logic [NPORTS-1:0]    fifo_af,
  output logic [15:0]          drop_cnt
);
  localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int DL = $clog2(DEPTH);
  localparam int CW = DL + 1;

  logic [AW-1:0] r_paddr [NPORTS];
  logic [PW-1:0] r_ptr   [NPORTS];
  logic [DW-1:0] r_mem_d [NPORTS][DEPTH];
  logic [PW-1:0] r_mem_s [NPORTS][DEPTH];
  logic [DL-1:0] r_wp    [NPORTS];
  logic [DL-1:0] r_rp    [NPORTS];
  logic [CW-1:0] r_cnt   [NPORTS];
  logic [DW-1:0] r_dout  [NPORTS];
  logic [PW-1:0] r_aout  [NPORTS];
  logic [15:0]   r_drop;

  logic [NPORTS-1:0] w_hit, w_push, w_pop, w_acc;
  logic [PW-1:0]     w_tgt    [NPORTS];
  logic [PW-1:0]     w_gnt    [NPORTS];
  logic [DW-1:0]     w_wdat   [NPORTS];
  logic [CW-1:0]     w_cnt_nx [NPORTS];
  logic [4:0]        w_ndrop;
  logic [16:0]       w_dsum;
  int                w_idx;

  // Descending scan so the lowest matching output index wins.
  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      w_hit[i] = 1'b0;
      w_tgt[i] = '0;
      for (int o = NPORTS - 1; o >= 0; o--) begin
        if (r_paddr[o] == addr_in[i*AW +: AW]) begin
          w_hit[i] = 1'b1;
          w_tgt[i] = PW'(o);
        end
      end
    end
  end

  always_comb begin
    w_push  = '0;
    w_acc   = '0;
    w_pop   = '0;
    w_ndrop = '0;
    w_idx   = 0;
    for (int o = 0; o < NPORTS; o++) begin
      w_gnt[o] = '0;
      // Farthest-to-nearest scan: the first requester after the last grant overwrites the others.
      for (int k = NPORTS; k >= 1; k--) begin
        w_idx = (int'(r_ptr[o]) + k) % NPORTS;
        if (r_cnt[o] != CW'(DEPTH) && wr_en[w_idx] && w_hit[w_idx] && w_tgt[w_idx] == PW'(o)) begin
          w_push[o] = 1'b1;
          w_gnt[o]  = PW'(w_idx);
        end
      end
      if (w_push[o]) w_acc[w_gnt[o]] = 1'b1;
      w_wdat[o]   = data_in[int'(w_gnt[o])*DW +: DW];
      w_pop[o]    = rd_en[o] && (r_cnt[o] != '0);
      w_cnt_nx[o] = r_cnt[o] + CW'(w_push[o]) - CW'(w_pop[o]);
    end
    for (int i = 0; i < NPORTS; i++) begin
      if (wr_en[i] && !w_hit[i]) begin
        w_acc[i] = 1'b1;
        w_ndrop  = w_ndrop + 5'd1;
      end
    end
    w_dsum = {1'b0, r_drop} + 17'(w_ndrop);
  end

  always_ff @(posedge clk) begin
    for (int o = 0; o < NPORTS; o++) begin
      if (w_push[o]) begin
        r_mem_d[o][r_wp[o]] <= w_wdat[o];
        r_mem_s[o][r_wp[o]] <= w_gnt[o];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int o = 0; o < NPORTS; o++) begin
        r_paddr[o] <= AW'(o);
        r_ptr[o]   <= PW'(NPORTS - 1);
        r_wp[o]    <= '0;
        r_rp[o]    <= '0;
        r_cnt[o]   <= '0;
        r_dout[o]  <= '0;
        r_aout[o]  <= '0;
      end
      r_drop <= '0;
    end else begin
      for (int o = 0; o < NPORTS; o++) begin
        if (port_en && port_wr && port_sel[o]) r_paddr[o] <= port_addr;
        if (w_push[o]) begin
          r_wp[o]  <= r_wp[o] + 1'b1;
          r_ptr[o] <= w_gnt[o];
        end
        if (w_pop[o]) r_rp[o] <= r_rp[o] + 1'b1;
        r_cnt[o] <= w_cnt_nx[o];
        // Head register tracks the next head; it holds its value once the FIFO drains.
        if (w_cnt_nx[o] != '0) begin
          if (r_cnt[o] == CW'(w_pop[o])) begin
            r_dout[o] <= w_wdat[o];
            r_aout[o] <= w_gnt[o];
          end else begin
            r_dout[o] <= r_mem_d[o][r_rp[o] + DL'(w_pop[o])];
            r_aout[o] <= r_mem_s[o][r_rp[o] + DL'(w_pop[o])];
          end
        end
      end
      r_drop <= w_dsum[16] ? 16'hFFFF : w_dsum[15:0];
    end
  end

  always_comb begin
    data_out   = '0;
    addr_out   = '0;
    data_rdy   = '0;
    fifo_empty = '0;
    fifo_full  = '0;
    fifo_ae    = '0;
    fifo_af    = '0;
    for (int o = 0; o < NPORTS; o++) begin
      data_out[o*DW +: DW] = r_dout[o];
      addr_out[o*AW +: AW] = AW'(r_aout[o]);
      data_rdy[o]          = (r_cnt[o] != '0);
      fifo_empty[o]        = (r_cnt[o] == '0);
      fifo_full[o]         = (r_cnt[o] == CW'(DEPTH));
      fifo_ae[o]           = (r_cnt[o] <= CW'(AE_LVL));
      fifo_af[o]           = (r_cnt[o] >= CW'(AF_LVL));
    end
  end

  assign data_rcv = w_acc;
  assign drop_cnt = r_drop;

endmodule

// File: doc/xswitch_param.md
XSWITCH_PARAM -- requirements
Module: xswitch_param

Interface
REQ-001 SHALL have parameter NPORTS, default 8, number of input and output ports (2..16).
REQ-002 SHALL have parameter DW, default 8, per-port data width.
REQ-003 SHALL have parameter AW, default 8, per-port address width.
REQ-004 SHALL have parameter DEPTH, default 8, per-output FIFO depth (power of 2, >=4).
REQ-005 SHALL have parameters AE_LVL, default 2, and AF_LVL, default DEPTH-2, almost-empty and almost-full thresholds.
REQ-006 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-007 SHALL have ports: reset  in  1  asynchronous, active-low reset.
REQ-008 SHALL have ports: addr_in  in  NPORTS*AW  destination address per input, slice i = input i; data_in  in  NPORTS*DW  payload per input; wr_en  in  NPORTS  per-input write request.
REQ-009 SHALL have ports: data_rcv  out  NPORTS  per-input accept, combinational, same cycle as accepted wr_en.
REQ-010 SHALL have ports: addr_out  out  NPORTS*AW  source input index of head entry, zero-extended; data_out  out  NPORTS*DW  head payload; data_rdy  out  NPORTS  output FIFO non-empty; rd_en  in  NPORTS  pop request.
REQ-011 SHALL have ports: port_en  in  1  config strobe; port_wr  in  1  config write; port_sel  in  NPORTS  one-hot/multi-hot output select; port_addr  in  AW  address value to program.
REQ-012 SHALL have ports: fifo_empty, fifo_full, fifo_ae, fifo_af  out  NPORTS each  per-output FIFO flags; drop_cnt  out  16  unmatched-packet counter.

Function
REQ-013 Each output o SHALL hold an AW-bit address register; input packet routes to the lowest-index output whose register equals addr_in slice.
REQ-014 port_en=1 and port_wr=1 at an edge SHALL load port_addr into every output register with port_sel bit set; new value effective the following cycle; port_en=1 with port_wr=0 is a no-op.
REQ-015 Per output, a round-robin arbiter SHALL grant at most one requesting input per cycle, searching from last-granted index+1 upward with wrap; pointer updates only on a grant.
REQ-016 data_rcv[i] SHALL be 1 iff wr_en[i]=1 and (input i granted and target FIFO not full, or no output address matches).
REQ-017 Inputs not accepted SHALL hold addr/data/wr_en; no entry is written for them.
REQ-018 Accepted packet with no matching address SHALL be discarded; drop_cnt increments by the number of such inputs that cycle, saturating at 16'hFFFF.
REQ-019 Accepted packet SHALL be written at the accepting edge; data_rdy and data_out valid in the next cycle (1-cycle latency).
REQ-020 FIFOs SHALL be show-ahead: data_out/addr_out reflect the head whenever data_rdy=1; rd_en=1 pops at the edge.
REQ-021 rd_en on an empty FIFO SHALL be ignored; data_out then holds last value.
REQ-022 Full FIFO SHALL block writes even if rd_en=1 in the same cycle; simultaneous read and write on a non-full, non-empty FIFO SHALL keep the count unchanged.
REQ-023 Flags SHALL be decoded from registered count: empty count=0, full count=DEPTH, ae count<=AE_LVL, af count>=AF_LVL; pointers wrap modulo DEPTH.

Reset
REQ-024 reset=0 SHALL asynchronously clear FIFO pointers/counts, drop_cnt=0, data_rdy=0, data_out=0, addr_out=0, fifo_empty=all 1, fifo_ae=all 1, fifo_full=0, fifo_af=0.
REQ-025 Reset SHALL set output o address register to o and every arbiter pointer to NPORTS-1 (input 0 first priority).
REQ-026 Reset asserted mid-transfer SHALL discard all FIFO contents; first accept after deassertion is at the first rising edge with reset=1.

Verification
REQ-027 After reset, input 3 writes addr=5, data=8'hA7 one cycle -> data_rcv[3]=1; next cycle data_rdy[5]=1, data_out[5]=8'hA7, addr_out[5]=3.
REQ-028 Inputs 0,1,2 all target output 4 for 3 cycles -> grants in order 0,1,2, each data_rcv held by stalled inputs until granted; FIFO 4 holds 3 entries in that order.
REQ-029 Write 8 packets to output 0 with no reads -> fifo_full[0]=1 after 8th, 9th write data_rcv=0; fifo_af[0]=1 at count 6; one rd_en with stalled writer -> write accepted next cycle.
REQ-030 Config port_sel=8'h02, port_addr=8'h40, then send addr 8'h40 -> lands in output 1; send addr 8'h01 -> drop_cnt=1, data_rcv=1.
REQ-031 Fill output 2 with 3 entries, assert reset=0 mid-cycle -> immediately fifo_empty[2]=1, data_rdy[2]=0, drop_cnt=0.
